// File: rtl/alarm_arm_ctrl.sv
// Keypad-driven arming/disarming sequencer with exit/entry delays, siren timing and wrong-code lockout.
// Optional panic key E is compiled in with `define ALARM_PANIC_EN.
module alarm_arm_ctrl #(
  parameter logic [15:0] CODE       = 16'h1234,
  parameter int          EXIT_DLY   = 8,
  parameter int          ENTRY_DLY  = 6,
  parameter int          SIREN_TIME = 20,
  parameter int          MAX_TRIES  = 3,
  parameter int          LOCK_TIME  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ENA,
  input  logic [3:0] keypad,
  input  logic       front_door,
  input  logic       rear_door,
  input  logic       window,
  output logic       alarm_siren,
  output logic       is_armed,
  output logic       is_wait_delay,
  output logic       lockout,
  output logic [2:0] digit_cnt
);

  localparam int MAX_AB = (EXIT_DLY > ENTRY_DLY) ? EXIT_DLY : ENTRY_DLY;
  localparam int MAX_CD = (SIREN_TIME > LOCK_TIME) ? SIREN_TIME : LOCK_TIME;
  localparam int TMAX   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int TW     = $clog2(TMAX + 1);
  localparam int FW     = $clog2(MAX_TRIES + 1);

  localparam logic [2:0] ST_DISARMED = 3'd0;
  localparam logic [2:0] ST_EXIT     = 3'd1;
  localparam logic [2:0] ST_ARMED    = 3'd2;
  localparam logic [2:0] ST_ENTRY    = 3'd3;
  localparam logic [2:0] ST_ALARM    = 3'd4;

  logic [2:0]    state;
  logic [2:0]    state_nx;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_val;
  logic          timer_load;
  logic          reload;
  logic [TW-1:0] lock_tmr;
  logic [FW-1:0] fail_cnt;
  logic [15:0]   digit_buf;
  logic          prev_key_held;

  logic key_event;
  logic is_digit;
  logic panic;
  logic digit_event;
  logic clear_event;
  logic code_ok;
  logic code_bad;
  logic penalty;
  logic disarmed_side;
  logic penalty_lock;
  logic penalty_alarm;
  logic timer_done;
  logic lock_done;
  logic door_open;

  // A key event is the first edge a non-zero key is seen after an idle edge.
  assign key_event = (keypad != 4'h0) && !prev_key_held;

`ifdef ALARM_PANIC_EN
  assign is_digit = (keypad >= 4'h1) && (keypad <= 4'hD);
  assign panic    = key_event && (keypad == 4'hE);
`else
  assign is_digit = (keypad >= 4'h1) && (keypad <= 4'hE);
  assign panic    = 1'b0;
`endif

  assign digit_event = key_event && !lockout && is_digit;
  assign clear_event = key_event && !lockout && (keypad == 4'hF);

  // The buffer is judged in the cycle after the fourth digit lands.
  assign code_ok  = (digit_cnt == 3'd4) && (digit_buf == CODE);
  assign code_bad = (digit_cnt == 3'd4) && (digit_buf != CODE);

  assign penalty       = code_bad && (fail_cnt >= FW'(MAX_TRIES - 1));
  assign disarmed_side = (state == ST_DISARMED) || (state == ST_EXIT);
  assign penalty_lock  = penalty && disarmed_side;
  assign penalty_alarm = penalty && !disarmed_side;

  assign timer_done = ENA && (timer == TW'(1));
  assign lock_done  = ENA && lockout && (lock_tmr == TW'(1));
  assign door_open  = front_door || rear_door;

  // Priority: code_ok > panic > penalty > window > doors > timer expiry.
  always_comb begin
    state_nx = state;
    reload   = 1'b0;
    if (code_ok) begin
      state_nx = (state == ST_DISARMED) ? ST_EXIT : ST_DISARMED;
    end else if (panic || penalty_alarm) begin
      state_nx = ST_ALARM;
      reload   = 1'b1;
    end else begin
      case (state)
        ST_EXIT: begin
          if (timer_done) state_nx = ST_ARMED;
        end
        ST_ARMED: begin
          if (window)         state_nx = ST_ALARM;
          else if (door_open) state_nx = ST_ENTRY;
        end
        ST_ENTRY: begin
          if (window || timer_done) state_nx = ST_ALARM;
        end
        ST_ALARM: begin
          if (timer_done) state_nx = ST_ARMED;
        end
        default: state_nx = state;
      endcase
    end
  end

  // Untimed states load zero so a leftover count can never expire later.
  always_comb begin
    timer_load = reload || (state_nx != state);
    case (state_nx)
      ST_EXIT:  timer_val = TW'(EXIT_DLY);
      ST_ENTRY: timer_val = TW'(ENTRY_DLY);
      ST_ALARM: timer_val = TW'(SIREN_TIME);
      default:  timer_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_DISARMED;
      timer <= '0;
    end else begin
      state <= state_nx;
      if (timer_load)
        timer <= timer_val;
      else if (ENA && (timer != '0))
        timer <= timer - TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      alarm_siren   <= 1'b0;
      is_armed      <= 1'b0;
      is_wait_delay <= 1'b0;
    end else begin
      alarm_siren   <= (state_nx == ST_ALARM);
      is_armed      <= (state_nx == ST_ARMED) || (state_nx == ST_ENTRY) ||
                       (state_nx == ST_ALARM);
      is_wait_delay <= (state_nx == ST_EXIT) || (state_nx == ST_ENTRY);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_key_held <= 1'b0;
      digit_buf     <= '0;
      digit_cnt     <= '0;
    end else begin
      prev_key_held <= (keypad != 4'h0);
      if (digit_cnt == 3'd4) begin
        digit_cnt <= '0;
        digit_buf <= '0;
      end else if (clear_event) begin
        digit_cnt <= '0;
        digit_buf <= '0;
      end else if (digit_event) begin
        digit_buf <= {digit_buf[11:0], keypad};
        digit_cnt <= digit_cnt + 3'd1;
      end
    end
  end

  // Fail counter holds at MAX_TRIES for the whole lockout, then clears.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fail_cnt <= '0;
      lockout  <= 1'b0;
      lock_tmr <= '0;
    end else begin
      if (code_ok) begin
        fail_cnt <= '0;
      end else if (penalty_alarm) begin
        fail_cnt <= '0;
      end else if (code_bad) begin
        if (fail_cnt < FW'(MAX_TRIES))
          fail_cnt <= fail_cnt + FW'(1);
      end else if (lock_done) begin
        fail_cnt <= '0;
      end

      if (penalty_lock) begin
        lockout  <= 1'b1;
        lock_tmr <= TW'(LOCK_TIME);
      end else if (lockout && ENA) begin
        lock_tmr <= lock_tmr - TW'(1);
        if (lock_tmr == TW'(1))
          lockout <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alarm_arm_ctrl.sv
// Directed bench for alarm_arm_ctrl: arming, entry delay, siren timing, lockout, clear key, reset abort.
// Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_alarm_arm_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       ENA;
  logic [3:0] keypad;
  logic       front_door;
  logic       rear_door;
  logic       window;
  logic       alarm_siren;
  logic       is_armed;
  logic       is_wait_delay;
  logic       lockout;
  logic [2:0] digit_cnt;

  int checks   = 0;
  int failures = 0;
  // {alarm_siren, is_armed, is_wait_delay, lockout} taken on the edge after a key event
  logic [3:0] snap;

  alarm_arm_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .ENA          (ENA),
    .keypad       (keypad),
    .front_door   (front_door),
    .rear_door    (rear_door),
    .window       (window),
    .alarm_siren  (alarm_siren),
    .is_armed     (is_armed),
    .is_wait_delay(is_wait_delay),
    .lockout      (lockout),
    .digit_cnt    (digit_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Key held for 3 edges then released for 1; digit_cnt checked on the event edge.
  task automatic press_key(input logic [3:0] k, input logic [2:0] exp_cnt);
    keypad = k;
    step();
    check_eq("digit_cnt", 16'(digit_cnt), 16'(exp_cnt));
    step();
    snap = {alarm_siren, is_armed, is_wait_delay, lockout};
    if (exp_cnt == 3'd4) check_eq("cnt_after_cmp", 16'(digit_cnt), 16'd0);
    step();
    keypad = 4'h0;
    step();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    check_eq("rst_outs", 16'({alarm_siren, is_armed, is_wait_delay, lockout}), 16'h0);
    check_eq("rst_cnt", 16'(digit_cnt), 16'd0);
    reset = 1'b1;
    step();
  endtask

  task automatic enter_code(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d);
    press_key(a, 3'd1);
    press_key(b, 3'd2);
    press_key(c, 3'd3);
    press_key(d, 3'd4);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; ENA = 1'b1; keypad = 4'h0;
    front_door = 1'b0; rear_door = 1'b0; window = 1'b0;
    snap = '0;

    // Reset, then arm with the correct code
    do_reset();
    enter_code(4'h1, 4'h2, 4'h3, 4'h4);
    check_eq("arm_start", 16'(snap), 16'b0010);
    repeat (5) step();
    check_eq("exit_last_tick", 16'({is_armed, is_wait_delay}), 16'b01);
    step();
    check_eq("armed_after_8", 16'({is_armed, is_wait_delay}), 16'b10);

    // Front door pulse: 6-tick entry delay, 20-tick siren, auto re-arm
    front_door = 1'b1;
    step();
    front_door = 1'b0;
    check_eq("entry_start", 16'({alarm_siren, is_armed, is_wait_delay}), 16'b011);
    repeat (5) step();
    check_eq("entry_last", 16'({alarm_siren, is_wait_delay}), 16'b01);
    step();
    check_eq("siren_on", 16'({alarm_siren, is_armed, is_wait_delay}), 16'b110);
    repeat (19) step();
    check_eq("siren_last", 16'(alarm_siren), 16'd1);
    step();
    check_eq("rearmed", 16'({alarm_siren, is_armed, is_wait_delay}), 16'b010);

    // Window while armed: immediate alarm, then disarm with the code
    window = 1'b1;
    step();
    window = 1'b0;
    check_eq("window_alarm", 16'(alarm_siren), 16'd1);
    enter_code(4'h1, 4'h2, 4'h3, 4'h4);
    check_eq("disarm_from_alarm", 16'(snap), 16'b0000);

    // Three wrong codes while disarmed: lockout for 10 ticks
    do_reset();
    enter_code(4'h1, 4'h1, 4'h1, 4'h1);
    check_eq("bad1", 16'(snap), 16'b0000);
    enter_code(4'h1, 4'h1, 4'h1, 4'h1);
    check_eq("bad2", 16'(snap), 16'b0000);
    enter_code(4'h1, 4'h1, 4'h1, 4'h1);
    check_eq("lock_start", 16'(snap), 16'b0001);
    press_key(4'h1, 3'd0);
    repeat (3) step();
    check_eq("lock_last", 16'(lockout), 16'd1);
    step();
    check_eq("lock_end", 16'(lockout), 16'd0);
    enter_code(4'h1, 4'h2, 4'h3, 4'h4);
    check_eq("arm_after_lock", 16'(snap), 16'b0010);

    // Clear key mid-entry, doors ignored during exit delay, reset aborts alarm
    do_reset();
    press_key(4'h1, 3'd1);
    press_key(4'h2, 3'd2);
    press_key(4'hF, 3'd0);
    enter_code(4'h1, 4'h2, 4'h3, 4'h4);
    check_eq("arm_after_clear", 16'(snap), 16'b0010);
    front_door = 1'b1;
    step();
    front_door = 1'b0;
    check_eq("door_in_exit", 16'({alarm_siren, is_armed, is_wait_delay}), 16'b001);
    repeat (4) step();
    check_eq("exit_last2", 16'({is_armed, is_wait_delay}), 16'b01);
    step();
    check_eq("armed2", 16'({is_armed, is_wait_delay}), 16'b10);
    window = 1'b1;
    step();
    check_eq("alarm2", 16'(alarm_siren), 16'd1);
    reset = 1'b0;
    step();
    window = 1'b0;
    check_eq("reset_abort", 16'({alarm_siren, is_armed, is_wait_delay, lockout}), 16'h0);
    reset = 1'b1;
    step();

    // Three wrong codes while armed: forced alarm
    do_reset();
    enter_code(4'h1, 4'h2, 4'h3, 4'h4);
    repeat (6) step();
    check_eq("armed3", 16'({is_armed, is_wait_delay}), 16'b10);
    enter_code(4'h2, 4'h2, 4'h2, 4'h2);
    enter_code(4'h2, 4'h2, 4'h2, 4'h2);
    check_eq("armed_bad2", 16'(snap), 16'b0100);
    enter_code(4'h2, 4'h2, 4'h2, 4'h2);
    check_eq("armed_penalty", 16'(snap), 16'b1100);

    // Key E: panic when enabled, ordinary digit otherwise
    do_reset();
`ifdef ALARM_PANIC_EN
    press_key(4'hE, 3'd0);
    check_eq("panic", 16'(snap), 16'b1100);
`else
    press_key(4'hE, 3'd1);
    check_eq("e_digit", 16'(snap), 16'b0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alarm_arm_ctrl.md
Name: alarm_arm_ctrl

Overview:
- Arming/disarming sequencer for the door/window alarm lab design.
- Collects 4-digit keypad codes, validates them against a parameterised code, and runs exit delay, entry delay and siren timing from the ENA tick.
- Drives the siren and status outputs. Sits between the raw keypad/sensor inputs and the board indicators.

Parameters:
- CODE, 16'h1234, four 4-bit digits, first-entered digit in [15:12]; each digit must be 1..D.
- EXIT_DLY, 8, ENA ticks from valid code to armed.
- ENTRY_DLY, 6, ENA ticks from door open to alarm.
- SIREN_TIME, 20, ENA ticks the siren sounds before auto re-arm.
- MAX_TRIES, 3, consecutive wrong codes before penalty.
- LOCK_TIME, 10, ENA ticks the keypad is ignored after MAX_TRIES failures while disarmed.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- ENA  in  1  timebase tick, one-cycle pulse; all delay counters step only when ENA=1.
- keypad  in  4  key value; 0 = no key, 1..D = digit, F = clear entry.
- front_door  in  1  1 = open.
- rear_door  in  1  1 = open.
- window  in  1  1 = open.
- alarm_siren  out  1  siren drive.
- is_armed  out  1  system armed.
- is_wait_delay  out  1  exit or entry delay running.
- lockout  out  1  keypad locked.
- digit_cnt  out  3  digits entered so far, 0..4.

Behaviour:
- reset=0 at a clk edge:
  - state=DISARMED; all outputs 0; digit buffer, fail counter and timers cleared.
  - Reset mid-delay or mid-alarm aborts immediately.
- Key event: keypad!=0 at this edge and keypad==0 at the previous edge (registered prev sample). A held key yields one event. Events are ignored while lockout=1.
- Key F clears the digit buffer (digit_cnt=0); no attempt is counted.
- Digits 1..D shift into the buffer, digit_cnt+1.
- 4th digit:
  - Compare in the cycle after the 4th digit is stored. Match gives a one-cycle internal code_ok; mismatch gives code_bad.
  - digit_cnt returns to 0 in that same cycle.
- code_ok clears the fail counter.
- code_bad increments the fail counter, saturating at MAX_TRIES. On reaching MAX_TRIES:
  - in DISARMED/EXIT_DELAY: lockout=1 for LOCK_TIME ENA ticks, then fail counter=0 and lockout=0;
  - in armed states: forced ALARM and fail counter=0.
- Timers load N on state entry and decrement on ENA. Expiry occurs on the ENA where timer==1, so exactly N ENA ticks elapse. The transition is registered and takes effect on the next edge.
- States and transitions. Within any state, priority is code_ok > penalty > window > doors > timer expiry.
  - DISARMED: code_ok -> EXIT_DELAY (load EXIT_DLY). Sensors ignored.
  - EXIT_DELAY: code_ok -> DISARMED; expiry -> ARMED. Sensors ignored.
  - ARMED:
    - code_ok -> DISARMED;
    - window=1 -> ALARM (load SIREN_TIME);
    - front_door|rear_door -> ENTRY_DELAY (load ENTRY_DLY).
  - ENTRY_DELAY: code_ok -> DISARMED; window=1 -> ALARM; expiry -> ALARM. Doors closing does not cancel the delay.
  - ALARM: code_ok -> DISARMED; expiry -> ARMED with siren off. If a door is still open on re-arm, ARMED re-enters ENTRY_DELAY on the next edge.
- Outputs are registered and decoded from the next state, so an output changes on the same edge as the state:
  - is_armed=1 in ARMED, ENTRY_DELAY, ALARM;
  - is_wait_delay=1 in EXIT_DELAY, ENTRY_DELAY;
  - alarm_siren=1 in ALARM only.
- ENA=0 permanently freezes all timers; state only changes on code or sensor events.
- Timer width is $clog2(max parameter + 1).

Optional Feature:
- ALARM_PANIC_EN defined:
  - key E is a panic key; its event forces ALARM (load SIREN_TIME) from any state, even while lockout=1;
  - panic ranks below code_ok;
  - E is never stored as a digit.
- ALARM_PANIC_EN undefined: E is an ordinary digit (CODE may then contain E); no panic path exists.

Test Plan:
- ENA every cycle; reset=0 for 2 cycles, then 1 -> all outputs 0, digit_cnt=0. Enter 1,2,3,4 (each key held 3 cycles, 0 between) -> is_wait_delay=1. Exactly 8 ENA ticks later -> is_armed=1, is_wait_delay=0.
- Armed, pulse front_door=1 for 1 cycle -> is_wait_delay=1 for 6 ENA ticks, then alarm_siren=1 for 20 ticks, then alarm_siren=0 with is_armed=1.
- Armed, window=1 -> alarm_siren=1 on the next edge. Enter 1234 -> all outputs 0 one cycle after compare.
- Disarmed, enter 1111 three times -> lockout=1 for 10 ENA ticks; keys during lockout leave digit_cnt=0. After lockout, 1234 arms normally.
- Enter 1,2,F,1,2,3,4 -> digit_cnt goes 1,2,0,1..4,0 and arming starts. During exit delay, front_door=1 -> no effect. Mid-ALARM reset=0 -> siren=0 next edge.
- ALARM_PANIC_EN defined: key E in DISARMED -> alarm_siren=1 next edge. Undefined: E increments digit_cnt.
